// File: rtl/zircon_ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package zircon_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  // Bit positions inside the first (header) byte of a mouse packet
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XSIGN = 4;
  localparam int YSIGN = 5;
  localparam int XOVF  = 6;
  localparam int YOVF  = 7;

  // Header fields kept between byte 0 and packet completion (sync bit dropped)
  typedef struct packed {
    logic       y_ovf;
    logic       x_ovf;
    logic       y_sign;
    logic       x_sign;
    logic [2:0] buttons;  // {middle, right, left}
  } pkt_hdr_t;

  function automatic int timeout_cycles(input int clk_hz, input int timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/zircon_ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizers, clock glitch filter,
// 11-bit frame FSM and inter-edge timeout.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit (0) on a clock fall
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, emitting byte or error
module zircon_ps2_frame_rx
  import zircon_ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       rx_enable,
  input  logic       pkt_busy,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int TO_CYC = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_US);
  localparam int TO_W   = $clog2(TO_CYC + 1);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  clk_filt;
  logic                  clk_filt_q;
  logic                  fall;
  logic                  dat_s;
  frame_state_t          state;
  frame_state_t          state_nxt;
  logic [7:0]            shreg;
  logic [2:0]            bit_cnt;
  logic                  par_bit;
  logic [TO_W-1:0]       to_cnt;
  logic                  to_hit;
  logic                  busy;
  logic                  frame_ok;

  // Synchronize both lines and debounce the clock with a full-agreement filter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      hist       <= '1;
      clk_filt   <= 1'b1;
      clk_filt_q <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk_in};
      dat_sync   <= {dat_sync[0], ps2_data_in};
      hist       <= {hist[FILTER_LEN-2:0], clk_sync[1]};
      if (&hist)
        clk_filt <= 1'b1;
      else if (~|hist)
        clk_filt <= 1'b0;
      clk_filt_q <= clk_filt;
    end
  end

  assign fall     = clk_filt_q & ~clk_filt;
  assign dat_s    = dat_sync[1];
  assign busy     = (state != ST_IDLE) || pkt_busy;
  assign to_hit   = rx_enable && busy && !fall && (to_cnt == '0);
  assign frame_ok = dat_s && (^{par_bit, shreg});

  // Down-counter reloaded on each clock fall; terminal count means the bus stalled
  always_ff @(posedge clk) begin
    if (!rst_n)
      to_cnt <= TO_W'(TO_CYC - 1);
    else if (!rx_enable || fall || !busy || to_hit)
      to_cnt <= TO_W'(TO_CYC - 1);
    else
      to_cnt <= to_cnt - 1'b1;
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode, advancing only on filtered clock falls
  always_comb begin
    state_nxt = state;
    if (!rx_enable || to_hit)
      state_nxt = ST_IDLE;
    else if (fall) begin
      case (state)
        ST_IDLE:   if (!dat_s) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      par_bit <= 1'b0;
    end else if (fall) begin
      case (state)
        ST_IDLE:   bit_cnt <= 3'd0;
        ST_DATA: begin
          shreg   <= {dat_s, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        ST_PARITY: par_bit <= dat_s;
        default:   ;
      endcase
    end
  end

  // Byte strobe or error strobe, issued in the stop-bit fall cycle or on timeout
  always_comb begin
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (rx_enable) begin
      if (to_hit)
        byte_err = 1'b1;
      else if (fall && (state == ST_STOP)) begin
        byte_valid = frame_ok;
        byte_err   = !frame_ok;
      end
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/zircon_ps2_mouse_packet_rx.sv
// PS/2 mouse receive front end: assembles 3-byte packets into increments,
// button flags and a sticky packet interrupt.
module zircon_ps2_mouse_packet_rx
  import zircon_ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic       csi_clk,
  input  logic       rsi_reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       rx_enable,
  input  logic       irq_ack,
  output logic [8:0] x_increment,
  output logic [8:0] y_increment,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic       x_overflow,
  output logic       y_overflow,
  output logic       packet_valid,
  output logic       frame_err,
  output logic       ins_interrupt
);

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;
  logic [1:0] byte_idx;
  pkt_hdr_t   hdr;
  logic [7:0] byte1;
  logic       pkt_done;

  zircon_ps2_frame_rx #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_frame (
    .clk        (csi_clk),
    .rst_n      (rsi_reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .rx_enable  (rx_enable),
    .pkt_busy   (byte_idx != 2'd0),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  assign pkt_done = byte_valid && (byte_idx == 2'd2);

  // Packet assembly; a header without the sync bit is dropped to regain alignment
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      byte_idx      <= 2'd0;
      hdr           <= '0;
      byte1         <= 8'h00;
      x_increment   <= 9'h000;
      y_increment   <= 9'h000;
      left_button   <= 1'b0;
      right_button  <= 1'b0;
      middle_button <= 1'b0;
      x_overflow    <= 1'b0;
      y_overflow    <= 1'b0;
      packet_valid  <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      packet_valid <= pkt_done;
      frame_err    <= byte_err;
      if (!rx_enable || byte_err)
        byte_idx <= 2'd0;
      else if (byte_valid) begin
        case (byte_idx)
          2'd0: begin
            if (byte_data[SYNC]) begin
              hdr.y_ovf   <= byte_data[YOVF];
              hdr.x_ovf   <= byte_data[XOVF];
              hdr.y_sign  <= byte_data[YSIGN];
              hdr.x_sign  <= byte_data[XSIGN];
              hdr.buttons <= {byte_data[BTN_M], byte_data[BTN_R], byte_data[BTN_L]};
              byte_idx    <= 2'd1;
            end
          end
          2'd1: begin
            byte1    <= byte_data;
            byte_idx <= 2'd2;
          end
          2'd2: begin
            x_increment   <= {hdr.x_sign, byte1};
            y_increment   <= {hdr.y_sign, byte_data};
            left_button   <= hdr.buttons[0];
            right_button  <= hdr.buttons[1];
            middle_button <= hdr.buttons[2];
            x_overflow    <= hdr.x_ovf;
            y_overflow    <= hdr.y_ovf;
            byte_idx      <= 2'd0;
          end
          default: byte_idx <= 2'd0;
        endcase
      end
    end
  end

  // Sticky interrupt; a completion in the same cycle as an ack keeps it set
  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n)
      ins_interrupt <= 1'b0;
    else if (pkt_done)
      ins_interrupt <= 1'b1;
    else if (irq_ack)
      ins_interrupt <= 1'b0;
  end

endmodule
